// File: rtl/hilo_multdiv_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hilo_multdiv_unit_if                                       |
// | Description : Execute-stage bundle between the pipeline control and the  |
// |               HI/LO multiply/divide unit (request, mfhi/mflo, results).  |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface hilo_multdiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             StartE;
  logic             DivE;
  logic             SignedE;
  logic [WIDTH-1:0] SrcAE;
  logic [WIDTH-1:0] SrcBE;
  logic             MfhiE;
  logic             MfloE;
  logic             FlushE;
  logic [WIDTH-1:0] HiLoOutE;
  logic             BusyE;
  logic             StallE;

  // Pipeline / hazard side
  modport master (
    output StartE, DivE, SignedE, SrcAE, SrcBE, MfhiE, MfloE, FlushE,
    input  HiLoOutE, BusyE, StallE
  );

  // Multiply/divide unit side
  modport slave (
    input  StartE, DivE, SignedE, SrcAE, SrcBE, MfhiE, MfloE, FlushE,
    output HiLoOutE, BusyE, StallE
  );
endinterface
`default_nettype wire

// File: rtl/hilo_multdiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : hilo_multdiv_unit                                          |
// | Description : Iterative radix-2 multiplier (optional restoring divider)  |
// |               with architectural HI/LO pair. WIDTH cycles per op.        |
// |               Macro HILO_MULTDIV_DIV_EN enables the divide path.         |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module hilo_multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic                Clk,
  input  logic                Rst_n,
  hilo_multdiv_unit_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   cnt;
  // Multiply: {partial product, remaining multiplier}. Divide: {remainder, dividend/quotient}.
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [WIDTH-1:0]   opb;
  logic               res_neg;
  logic [WIDTH-1:0]   hi;
  logic [WIDTH-1:0]   lo;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  logic               start_ok;
  logic               last_step;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] mul_res;

`ifdef HILO_MULTDIV_DIV_EN
  logic               is_div;
  logic               rem_neg;
  logic               div_zero;
  logic [WIDTH:0]     div_trial;
  logic [2*WIDTH-1:0] div_next;
`else
  logic               unused_div;
  assign unused_div = bus.DivE;
`endif

  assign start_ok  = (state == IDLE) && bus.StartE && !bus.FlushE;
  assign last_step = (state == RUN) && (cnt == CNT_W'(1));

  assign bus.BusyE  = (state == RUN);
  assign bus.StallE = bus.BusyE && (bus.StartE || bus.MfhiE || bus.MfloE);

  // HI wins when both move-from instructions are present
  assign bus.HiLoOutE = bus.MfhiE ? hi : (bus.MfloE ? lo : '0);

  // Operand magnitudes; signed ops iterate on unsigned values and fix the sign at the end
  always_comb begin
    mag_a = bus.SrcAE;
    mag_b = bus.SrcBE;
    if (bus.SignedE && bus.SrcAE[WIDTH-1]) mag_a = -bus.SrcAE;
    if (bus.SignedE && bus.SrcBE[WIDTH-1]) mag_b = -bus.SrcBE;
  end

  // One shift-add (or shift-subtract) step and the sign-corrected final result
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
    mul_next = {mul_sum, acc[WIDTH-1:1]};
    mul_res  = res_neg ? -mul_next : mul_next;
    acc_next = mul_next;
    res_hi   = mul_res[2*WIDTH-1:WIDTH];
    res_lo   = mul_res[WIDTH-1:0];
`ifdef HILO_MULTDIV_DIV_EN
    // Trial subtract on {remainder, next dividend bit}; a set MSB means it went negative
    div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opb};
    if (div_trial[WIDTH]) begin
      div_next = {acc[2*WIDTH-2:0], 1'b0};
    end else begin
      div_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
    if (is_div) begin
      acc_next = div_next;
      // Divide by zero leaves |A| in the remainder; re-signing it restores the raw dividend
      res_hi   = rem_neg ? -div_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
      if (div_zero) begin
        res_lo = '1;
      end else begin
        res_lo = res_neg ? -div_next[WIDTH-1:0] : div_next[WIDTH-1:0];
      end
    end
`endif
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok) state_next = RUN;
      RUN:     if (last_step) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath: latch operands on start, iterate while running, commit HI/LO on the last step
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      cnt      <= '0;
      acc      <= '0;
      opb      <= '0;
      res_neg  <= 1'b0;
      hi       <= '0;
      lo       <= '0;
`ifdef HILO_MULTDIV_DIV_EN
      is_div   <= 1'b0;
      rem_neg  <= 1'b0;
      div_zero <= 1'b0;
`endif
    end else if (state == IDLE) begin
      if (start_ok) begin
        acc      <= {{WIDTH{1'b0}}, mag_a};
        opb      <= mag_b;
        res_neg  <= bus.SignedE && (bus.SrcAE[WIDTH-1] ^ bus.SrcBE[WIDTH-1]);
        cnt      <= CNT_W'(WIDTH);
`ifdef HILO_MULTDIV_DIV_EN
        is_div   <= bus.DivE;
        rem_neg  <= bus.SignedE && bus.DivE && bus.SrcAE[WIDTH-1];
        div_zero <= (bus.SrcBE == '0);
`endif
      end
    end else begin
      acc <= acc_next;
      cnt <= cnt - CNT_W'(1);
      if (last_step) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hilo_multdiv_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_hilo_multdiv_unit                                       |
// | Description : Scoreboard bench: stimulus queues expected mfhi/mflo data, |
// |               a monitor pops and compares on every unstalled read.       |
// |               Macro HILO_MULTDIV_DIV_EN adds the divide cases.           |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_hilo_multdiv_unit;
  localparam int W = 32;

  logic Clk = 1'b0;
  logic Rst_n = 1'b0;

  hilo_multdiv_unit_if #(.WIDTH(W)) bus ();

  hilo_multdiv_unit #(.WIDTH(W)) dut (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;
  int busy_cycles = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  // Reference: plain 64-bit arithmetic; divide truncates toward zero, remainder follows dividend
  function automatic logic [63:0] model_op(input logic [31:0] a, input logic [31:0] b,
                                           input bit sgn, input bit dv);
    longint pa, pb, r;
    bit dv_eff;
`ifdef HILO_MULTDIV_DIV_EN
    dv_eff = dv;
`else
    dv_eff = 1'b0 & dv;
`endif
    pa = sgn ? longint'($signed(a)) : longint'({32'b0, a});
    pb = sgn ? longint'($signed(b)) : longint'({32'b0, b});
    if (dv_eff) begin
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      r = pa % pb;
      pa = pa / pb;
      return {r[31:0], pa[31:0]};
    end
    r = pa * pb;
    return r;
  endfunction

  // Busy-cycle tally
  always @(negedge Clk) if (bus.BusyE) busy_cycles++;

  // Monitor: every mfhi/mflo that is not stalled commits, so compare it against the scoreboard
  always @(negedge Clk) begin
    if (Rst_n && (bus.MfhiE || bus.MfloE) && !bus.StallE) begin
      if (exp_q.size() == 0) check("unexpected_read", 64'(bus.HiLoOutE), 64'hDEAD);
      else check("hilo_read", 64'(bus.HiLoOutE), 64'(exp_q.pop_front()));
    end
  end

  task automatic do_start(input logic [31:0] a, input logic [31:0] b, input bit sgn,
                          input bit dv, input bit flush, output int stalls);
    bit busy_before;
    int guard;
    logic [63:0] res;
    bus.SrcAE = a; bus.SrcBE = b; bus.SignedE = sgn; bus.DivE = dv;
    bus.StartE = 1'b1; bus.FlushE = flush;
    stalls = 0; guard = 0;
    forever begin
      @(negedge Clk);
      busy_before = bus.BusyE;
      if (bus.StallE) stalls++;
      @(posedge Clk); #1;
      guard++;
      if (!busy_before || guard > 200) break;
    end
    bus.StartE = 1'b0; bus.FlushE = 1'b0;
    if (guard > 200) check("start_timeout", 64'(guard), 64'd200);
    if (!flush) begin
      res = model_op(a, b, sgn, dv);
      model_hi = res[63:32];
      model_lo = res[31:0];
    end
  endtask

  task automatic do_mf(input bit hi_sel, input bit both, input logic [31:0] exp, output int stalls);
    bit stalled;
    int guard;
    bus.MfhiE = hi_sel | both;
    bus.MfloE = !hi_sel | both;
    exp_q.push_back(exp);
    stalls = 0; guard = 0;
    forever begin
      @(negedge Clk);
      stalled = bus.StallE;
      if (stalled) stalls++;
      @(posedge Clk); #1;
      guard++;
      if (!stalled || guard > 200) break;
    end
    bus.MfhiE = 1'b0; bus.MfloE = 1'b0;
    if (guard > 200) check("mf_timeout", 64'(guard), 64'd200);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge Clk);
    while (bus.BusyE && guard < 200) begin
      @(negedge Clk);
      guard++;
    end
    if (guard >= 200) check("idle_timeout", 64'(guard), 64'd0);
    @(posedge Clk); #1;
  endtask

  task automatic read_both();
    int s;
    do_mf(1'b1, 1'b0, model_hi, s);
    do_mf(1'b0, 1'b0, model_lo, s);
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s, s2, b0;
    logic [31:0] a, b;
    bus.StartE = 0; bus.DivE = 0; bus.SignedE = 0; bus.SrcAE = '0; bus.SrcBE = '0;
    bus.MfhiE = 0; bus.MfloE = 0; bus.FlushE = 0;
    repeat (3) @(posedge Clk);
    #1 Rst_n = 1'b1;
    @(negedge Clk);
    check("reset_busy", 64'(bus.BusyE), 64'd0);
    check("reset_stall", 64'(bus.StallE), 64'd0);
    check("reset_out", 64'(bus.HiLoOutE), 64'd0);
    @(posedge Clk); #1;
    do_mf(1'b1, 1'b0, 32'h0, s);
    do_mf(1'b0, 1'b0, 32'h0, s);

    // multu 6*7 with busy-length check
    b0 = busy_cycles;
    do_start(32'd6, 32'd7, 1'b0, 1'b0, 1'b0, s);
    wait_idle();
    check("mul_busy_len", 64'(busy_cycles - b0), 64'd32);
    do_mf(1'b1, 1'b0, 32'h0000_0000, s);
    do_mf(1'b0, 1'b0, 32'h0000_002A, s);

    do_start(32'hFFFF_FFFD, 32'h5, 1'b1, 1'b0, 1'b0, s);
    wait_idle();
    do_mf(1'b1, 1'b0, 32'hFFFF_FFFF, s);
    do_mf(1'b0, 1'b0, 32'hFFFF_FFF1, s);
    do_start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, s);
    wait_idle();
    do_mf(1'b1, 1'b0, 32'hFFFF_FFFE, s);
    do_mf(1'b0, 1'b0, 32'h0000_0001, s);
    do_start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, s);
    wait_idle();
    do_mf(1'b1, 1'b0, 32'h0, s);
    do_mf(1'b0, 1'b0, 32'h1, s);

    // mflo one cycle behind the start: stalled for the remaining busy cycles
    do_start(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b0, 1'b0, s);
    @(posedge Clk); #1;
    do_mf(1'b0, 1'b0, model_lo, s);
    check("mflo_stall_cycles", 64'(s), 64'd31);
    do_mf(1'b1, 1'b1, model_hi, s);

    // Back-to-back starts
    b0 = busy_cycles;
    do_start(32'd1000, 32'd3000, 1'b0, 1'b0, 1'b0, s);
    do_start(32'h8000_0000, 32'd3, 1'b1, 1'b0, 1'b0, s2);
    check("b2b_stall_cycles", 64'(s2), 64'd32);
    wait_idle();
    check("b2b_busy_len", 64'(busy_cycles - b0), 64'd64);
    read_both();

    // Flushed start is ignored
    b0 = busy_cycles;
    do_start(32'd9, 32'd9, 1'b0, 1'b0, 1'b1, s);
    @(negedge Clk);
    check("flush_busy", 64'(bus.BusyE), 64'd0);
    repeat (3) @(posedge Clk);
    #1;
    check("flush_busy_len", 64'(busy_cycles - b0), 64'd0);
    read_both();

    // Reset in the middle of an operation
    do_start(32'd77, 32'd99, 1'b0, 1'b0, 1'b0, s);
    repeat (9) @(posedge Clk);
    #1 Rst_n = 1'b0;
    @(posedge Clk);
    #1 Rst_n = 1'b1;
    model_hi = '0; model_lo = '0;
    @(negedge Clk);
    check("midreset_busy", 64'(bus.BusyE), 64'd0);
    @(posedge Clk); #1;
    read_both();
    do_start(32'hFFFF_FFF0, 32'd16, 1'b1, 1'b0, 1'b0, s);
    wait_idle();
    read_both();

`ifdef HILO_MULTDIV_DIV_EN
    do_start(32'd100, 32'd7, 1'b0, 1'b1, 1'b0, s);
    wait_idle();
    do_mf(1'b1, 1'b0, 32'd2, s);
    do_mf(1'b0, 1'b0, 32'd14, s);
    b0 = busy_cycles;
    do_start(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, 1'b0, s);
    wait_idle();
    check("div_busy_len", 64'(busy_cycles - b0), 64'd32);
    do_mf(1'b1, 1'b0, 32'hFFFF_FFFF, s);
    do_mf(1'b0, 1'b0, 32'hFFFF_FFFD, s);
    do_start(32'd5, 32'd0, 1'b0, 1'b1, 1'b0, s);
    wait_idle();
    do_mf(1'b1, 1'b0, 32'd5, s);
    do_mf(1'b0, 1'b0, 32'hFFFF_FFFF, s);
    do_start(32'hFFFF_FF00, 32'd0, 1'b1, 1'b1, 1'b0, s);
    wait_idle();
    read_both();
    do_start(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, s);
    wait_idle();
    read_both();
`endif

    // Randomized operations, with an occasional read issued while busy
    for (int i = 0; i < 30; i++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 15));
      if ($urandom_range(0, 5) == 0) a = 32'($urandom_range(0, 3)) << 30;
      do_start(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, s);
      if ($urandom_range(0, 1) == 1) do_mf(1'($urandom_range(0, 1)), 1'b0,
                                           32'h0, s);
      wait_idle();
      read_both();
    end

    repeat (3) @(posedge Clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // A read issued during the random loop must see the completed result; patch its queued value
  always @(posedge Clk) begin
    if ((bus.MfhiE || bus.MfloE) && exp_q.size() == 1 && exp_q[0] == 32'h0 && bus.BusyE) begin
      exp_q[0] = bus.MfhiE ? model_hi : model_lo;
    end
  end

endmodule
`default_nettype wire

// File: doc/hilo_multdiv_unit.md
Name: hilo_multdiv_unit

Overview:
Iterative multiply (and optionally divide) unit for the execute stage, with an architectural HI/LO register pair.
- Accepts mult/multu from decode/execute control and computes in the background while the pipeline advances.
- Drives mfhi/mflo results onto the ExecuteOutE mux that feeds the execute/memory pipeline register.
- Raises a stall request to the hazard unit when a HI/LO consumer or a new op arrives while busy.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count = WIDTH.

Ports:
- Clk  in  1  pipeline clock.
- Rst_n  in  1  synchronous reset, active-low.
- StartE  in  1  mult/multu (or div/divu) in execute stage.
- DivE  in  1  with StartE: 1 = divide, 0 = multiply (ignored unless DIV_EN).
- SignedE  in  1  with StartE: 1 = signed, 0 = unsigned.
- SrcAE  in  WIDTH  operand A (multiplicand/dividend).
- SrcBE  in  WIDTH  operand B (multiplier/divisor).
- MfhiE  in  1  mfhi in execute stage.
- MfloE  in  1  mflo in execute stage.
- FlushE  in  1  execute-stage clear from hazard unit.
- HiLoOutE  out  WIDTH  HI when MfhiE, LO when MfloE, else 0 (combinational).
- BusyE  out  1  operation in progress.
- StallE  out  1  stall request to hazard unit.

Behaviour:
- Reset (Rst_n=0 at posedge): state IDLE, HI=0, LO=0, iteration counter=0, internal accumulators=0, BusyE=0. Reset mid-operation aborts it; HI/LO are not updated.
- States: IDLE, RUN.
- IDLE -> RUN at a posedge with StartE=1, FlushE=0, Rst_n=1.
  - Latch |A| and |B| (magnitudes only if SignedE, else raw values).
  - Latch result sign (A[msb]^B[msb], signed only) and remainder sign (A[msb], signed divide only).
  - Load counter with WIDTH.
- RUN, multiply: one radix-2 shift-add step per cycle on a 2*WIDTH-bit product; counter decrements.
- RUN, divide: one restoring shift-subtract step per cycle; counter decrements.
- RUN -> IDLE at the posedge where counter reaches 0 (the WIDTH-th RUN edge). HI/LO are written on that same edge, with sign correction (two's-complement negate) applied.
  - Multiply: {HI,LO} = product.
  - Divide: LO = quotient, HI = remainder.
- Latency: start edge = E0; HI/LO valid after edge E0+WIDTH. BusyE=1 for exactly WIDTH cycles, between those edges.
- BusyE = (state==RUN). StallE = BusyE & (StartE | MfhiE | MfloE).
- A StartE that arrives while busy is not accepted. The hazard unit holds the instruction in execute, and the op is accepted at the first IDLE edge.
- MfhiE/MfloE while busy: HiLoOutE still reflects the old HI/LO, but StallE holds the pipeline, so no stale value is committed.
- MfhiE and MfloE both high: HI has priority.
- FlushE in IDLE blocks the start. FlushE during RUN does not abort (the issuing instruction has already left execute).
- Operations between StartE and completion never modify HI/LO. Only completion or reset writes them.

Optional Feature:
- Macro HILO_MULTDIV_DIV_EN.
- Defined: DivE selects the restoring divider (same WIDTH-cycle latency). Signed divide truncates toward zero; the remainder takes the dividend's sign.
  - Divide by zero: LO = all ones, HI = dividend (raw SrcAE); still WIDTH cycles.
- Undefined: DivE is ignored; every start is a multiply; no divider logic is synthesized.

Test Plan:
- multu 6*7, then mflo after idle -> BusyE high 32 cycles; HI=0x00000000, LO=0x0000002A; HiLoOutE=0x2A on mflo.
- mult signed -3*5 (0xFFFFFFFD, 0x00000005) -> HI=0xFFFFFFFF, LO=0xFFFFFFF1. Then multu 0xFFFFFFFF*0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Then mult signed same operands -> HI=0, LO=1.
- mflo issued the cycle after start -> StallE=1 for 31 remaining busy cycles, deasserts at completion edge; next cycle HiLoOutE=new LO.
- Back-to-back: second StartE during RUN -> StallE=1 until IDLE, second op accepted on first IDLE edge, total 64 busy cycles. Start with FlushE=1 -> ignored, BusyE stays 0.
- Rst_n low at RUN cycle 10 -> next cycle IDLE, BusyE=0, HI=LO=0. StartE without FlushE after reset -> runs normally.
- (HILO_MULTDIV_DIV_EN) divu 100/7 -> LO=14, HI=2. div -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 5/0 -> LO=0xFFFFFFFF, HI=5.
